i2s_clk_gen: RTL and testbench
==============================

Name: i2s_clk_gen

Overview:
- I2S master clock generator feeding the I2S receive and transmit stages, derived from the fabric clock.
- Produces free-running mclk plus gated sclk/lrck, with clk-domain strobes (sclk edges, frame start, slot index) so downstream stages sample/shift synchronously without re-synchronising the codec clocks.
- Start/stop is frame-aligned and glitch-free.

Parameters:
- MCLK_DIV, 4, clk cycles per mclk period; even, >=2.
- SCLK_DIV, 8, mclk periods per sclk period; even, >=2.
- BITS_PER_CH, 32, sclk periods per channel slot (frame = 2*BITS_PER_CH).
- Defaults: clk 90.3168 MHz gives mclk 22.5792 MHz, sclk 2.8224 MHz, lrck 44.1 kHz.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  run request for sclk/lrck
- mclk  out  1  master clock to codec, free-running after reset
- sclk  out  1  serial bit clock
- lrck  out  1  word select: 0 = left, 1 = right
- sclk_rise  out  1  1-cycle strobe, the cycle after sclk goes 0->1
- sclk_fall  out  1  1-cycle strobe, the cycle after sclk goes 1->0
- frame_start  out  1  1-cycle strobe coincident with the sclk_fall that starts slot 0
- slot  out  $clog2(2*BITS_PER_CH)  current bit index in the frame, 0..2*BITS_PER_CH-1
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst low, async): all outputs 0; FSM = IDLE; all counters 0.
- All outputs are registered; there are no combinational paths from en.

mclk:
- After reset release, toggles every MCLK_DIV/2 clk cycles, starting low.
- First rise occurs MCLK_DIV/2 cycles after the first clk edge with rst high.
- Independent of en and FSM state.

Phase counter:
- Counts clk cycles modulo P = MCLK_DIV*SCLK_DIV.
- sclk rises when the counter reaches P/2 and falls when it wraps to 0.
- sclk_rise/sclk_fall assert for exactly one clk, in the cycle after the respective transition edge.

FSM:
- IDLE: sclk = 0, lrck = 0, slot = 0, no strobes.
  - Exits to RUN when en = 1 and the mclk counter = 0, keeping sclk edges aligned to mclk falling edges.
  - On entry, the phase counter starts at 0; the first sclk rise is P/2 cycles later.
- RUN: on each sclk fall, slot increments, wrapping 2*BITS_PER_CH-1 -> 0.
  - lrck is updated on the same edge: lrck = (slot_next >= BITS_PER_CH).
  - frame_start pulses when slot wraps to 0.
  - en = 0 -> DRAIN.
- DRAIN: identical to RUN until the sclk fall that would wrap slot to 0, then -> IDLE.
  - At that edge: sclk = 0, lrck = 0, slot = 0, no frame_start pulse.
  - en = 1 during DRAIN -> back to RUN with no gap and no phase reset.

Boundary conditions:
- en toggled low then high within one sclk period in RUN: frame continues uninterrupted.
- en = 0 asserted exactly on the final slot's fall edge: that edge ends the frame, so the FSM goes to IDLE immediately.
- Reset mid-frame: all outputs drop to 0 asynchronously; after release, mclk restarts low and the FSM is in IDLE.

Decomposition:
- Shared package i2s_pkg holds:
  - default constants I2S_MCLK_DIV, I2S_SCLK_DIV, I2S_BITS_PER_CH;
  - a slot-index width function;
  - the FSM typedef enum {IDLE, RUN, DRAIN}.
- One sub-module, i2s_div_ctr: parameterised modulo counter with a half/wrap strobe output. Instantiated once for mclk and once for the sclk phase.

Test Plan:
- Parameters MCLK_DIV=2, SCLK_DIV=2, BITS_PER_CH=4 (P=4, frame=32 clk); reset release with en=0 -> mclk toggles every clk cycle (period 2); sclk, lrck, busy stay 0 for 100 cycles.
- Same parameters; en=1 at mclk counter=0 -> first sclk rise 2 cycles later, sclk period 4; lrck rises on the fall ending slot 3; frame_start every 32 clk; slot sequence 0..7.
- Defaults; run 2 frames -> mclk period 4, sclk period 32, lrck period 2048 clk, 50% duty on all three.
- en deasserted mid-slot 5 (small parameters) -> slots 6, 7 complete, then sclk=0, lrck=0, busy=0, with no frame_start on the final fall; en reasserted during slot 6 instead -> slot 7 wraps to 0 with frame_start and busy stays 1.
- rst asserted during slot 2 -> all outputs 0 within the same cycle (async); after release, mclk restarts low and sclk stays 0 until en is sampled with the mclk counter at 0.
- Strobe check -> exactly one sclk_rise and one sclk_fall per sclk period, never both asserted together; frame_start always coincides with sclk_fall and slot=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, slot-width helper and FSM state type for the I2S clock generator.
package i2s_pkg;

    localparam int I2S_MCLK_DIV    = 4;
    localparam int I2S_SCLK_DIV    = 8;
    localparam int I2S_BITS_PER_CH = 32;

    function automatic int slot_width(input int bits_per_ch);
        return $clog2(2 * bits_per_ch);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;

endpackage

// File: rtl/i2s_div_ctr.sv
// Modulo-DIV counter with a single strobe that fires on the edges where the
// count reaches DIV/2 and where it wraps to 0; clr holds the count at 0.
module i2s_div_ctr #(
    parameter int DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output logic [$clog2(DIV)-1:0] cnt,
    output logic                   tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2);

    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (!clr && cnt != LAST) cnt_next = cnt + W'(1);
    end

    assign tick = !clr && ((cnt_next == HALF) || (cnt == LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_next;
    end

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S master clock generator: free-running mclk, frame-aligned gated sclk/lrck,
// and clk-domain strobes for the receive/transmit stages.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV    = I2S_MCLK_DIV,
    parameter int SCLK_DIV    = I2S_SCLK_DIV,
    parameter int BITS_PER_CH = I2S_BITS_PER_CH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    output logic                                mclk,
    output logic                                sclk,
    output logic                                lrck,
    output logic                                sclk_rise,
    output logic                                sclk_fall,
    output logic                                frame_start,
    output logic [slot_width(BITS_PER_CH)-1:0]  slot,
    output logic                                busy
);

    localparam int P     = MCLK_DIV * SCLK_DIV;
    localparam int NSLOT = 2 * BITS_PER_CH;
    localparam int SW    = slot_width(BITS_PER_CH);
    localparam int MW    = $clog2(MCLK_DIV);
    localparam int PW    = $clog2(P);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NSLOT - 1);
    localparam logic [SW-1:0] SLOT_RIGHT = SW'(BITS_PER_CH);
    localparam logic [PW-1:0] PH_HALF    = PW'(P / 2);

    i2s_state_t    state, state_next;
    logic [MW-1:0] mclk_cnt;
    logic          mclk_tick, mclk_pre;
    logic [PW-1:0] ph_cnt;
    logic          ph_tick, ph_clr;
    logic          rise_evt, fall_evt, last_fall;
    logic [SW-1:0] slot_inc, slot_n;
    logic          sclk_n, lrck_n, rise_n, fall_n, fs_n, busy_n;

    i2s_div_ctr #(.DIV(MCLK_DIV)) u_mclk_ctr (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .cnt (mclk_cnt),
        .tick(mclk_tick)
    );

    assign ph_clr = (state == IDLE);

    i2s_div_ctr #(.DIV(P)) u_phase_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ph_clr),
        .cnt (ph_cnt),
        .tick(ph_tick)
    );

    // A tick seen from the upper half of the phase is the wrap, i.e. the sclk fall.
    assign fall_evt  = ph_tick && (ph_cnt >= PH_HALF);
    assign rise_evt  = ph_tick && (ph_cnt <  PH_HALF);
    assign last_fall = fall_evt && (slot == SLOT_LAST);
    assign slot_inc  = (slot == SLOT_LAST) ? '0 : slot + SW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (en && mclk_cnt == '0) state_next = RUN;
            RUN, DRAIN: if (!en) state_next = last_fall ? IDLE : DRAIN;
                        else     state_next = RUN;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        sclk_n = sclk;
        lrck_n = lrck;
        slot_n = slot;
        rise_n = 1'b0;
        fall_n = 1'b0;
        fs_n   = 1'b0;
        busy_n = (state_next != IDLE);
        if (state == IDLE) begin
            sclk_n = 1'b0;
            lrck_n = 1'b0;
            slot_n = '0;
        end else if (rise_evt) begin
            sclk_n = 1'b1;
            rise_n = 1'b1;
        end else if (fall_evt) begin
            sclk_n = 1'b0;
            fall_n = 1'b1;
            if (state_next == IDLE) begin
                lrck_n = 1'b0;
                slot_n = '0;
            end else begin
                slot_n = slot_inc;
                lrck_n = (slot_inc >= SLOT_RIGHT);
                fs_n   = (slot_inc == '0);
            end
        end
    end

    // mclk_pre leads by one cycle so the registered mclk first rises MCLK_DIV/2 edges after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mclk_pre    <= 1'b0;
            mclk        <= 1'b0;
            sclk        <= 1'b0;
            lrck        <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            slot        <= '0;
            busy        <= 1'b0;
        end else begin
            mclk_pre    <= mclk_pre ^ mclk_tick;
            mclk        <= mclk_pre;
            sclk        <= sclk_n;
            lrck        <= lrck_n;
            sclk_rise   <= rise_n;
            sclk_fall   <= fall_n;
            frame_start <= fs_n;
            slot        <= slot_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Bench for i2s_clk_gen: small-parameter instance against a frame-arithmetic
// reference model, plus a default-parameter instance checked for periods/duty.
module tb_i2s_clk_gen;

    localparam int S_MD = 2, S_SD = 2, S_B = 4;
    localparam int S_P  = S_MD * S_SD;
    localparam int S_NS = 2 * S_B;
    localparam int D_MD = 4, D_SD = 8, D_B = 32;
    localparam int D_P  = D_MD * D_SD;
    localparam int D_NS = 2 * D_B;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_s = 1'b0;
    logic en_d = 1'b0;

    logic s_mclk, s_sclk, s_lrck, s_rise, s_fall, s_fs, s_busy;
    logic [2:0] s_slot;
    logic d_mclk, d_sclk, d_lrck, d_rise, d_fall, d_fs, d_busy;
    logic [5:0] d_slot;

    int checks = 0;
    int errors = 0;

    i2s_clk_gen #(.MCLK_DIV(S_MD), .SCLK_DIV(S_SD), .BITS_PER_CH(S_B)) dut (
        .clk(clk), .rst(rst), .en(en_s), .mclk(s_mclk), .sclk(s_sclk), .lrck(s_lrck),
        .sclk_rise(s_rise), .sclk_fall(s_fall), .frame_start(s_fs), .slot(s_slot), .busy(s_busy)
    );

    i2s_clk_gen #(.MCLK_DIV(D_MD), .SCLK_DIV(D_SD), .BITS_PER_CH(D_B)) dut_def (
        .clk(clk), .rst(rst), .en(en_d), .mclk(d_mclk), .sclk(d_sclk), .lrck(d_lrck),
        .sclk_rise(d_rise), .sclk_fall(d_fall), .frame_start(d_fs), .slot(d_slot), .busy(d_busy)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {s_mclk, s_sclk, s_lrck, s_rise, s_fall, s_fs, s_slot, s_busy};

    // Reference model: mk = edges since reset release, m_n = edges since run entry.
    int mk = -1;
    int m_n = 0;
    bit m_run = 1'b0;
    bit m_stop = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mk = -1; m_n = 0; m_run = 1'b0; m_stop = 1'b0;
        end else begin
            mk = mk + 1;
            m_stop = 1'b0;
            if (!m_run) begin
                if (en_s && (mk % S_MD) == 0) begin
                    m_run = 1'b1;
                    m_n = 0;
                end
            end else begin
                m_n = m_n + 1;
                if ((m_n % S_P) == 0 && ((m_n / S_P) % S_NS) == 0 && !en_s) begin
                    m_run = 1'b0;
                    m_stop = 1'b1;
                end
            end
        end
    end

    function automatic int m_slot();
        return (m_n / S_P) % S_NS;
    endfunction

    function automatic int m_ph();
        return m_n % S_P;
    endfunction

    function automatic logic [9:0] model_vec();
        logic m, s, l, r, f, fsv, b;
        int ph, sl;
        logic [2:0] slv;
        m = (mk < 0) ? 1'b0 : (((mk / (S_MD / 2)) % 2) == 1);
        s = 0; l = 0; r = 0; f = 0; fsv = 0; b = 0; sl = 0;
        if (m_stop) begin
            f = 1'b1;
        end else if (m_run) begin
            ph  = m_n % S_P;
            sl  = (m_n / S_P) % S_NS;
            s   = (ph >= S_P / 2);
            l   = (sl >= S_B);
            r   = (ph == S_P / 2);
            f   = (ph == 0) && (m_n > 0);
            fsv = f && (sl == 0);
            b   = 1'b1;
        end
        slv = 3'(sl);
        return {m, s, l, r, f, fsv, slv, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_small: got %b want %b", obs, 10'b0);
        end
        checks++;
        if ({d_mclk, d_sclk, d_lrck, d_rise, d_fall, d_fs, d_slot, d_busy} !== 13'b0) begin
            errors++;
            $display("FAIL reset_default: got %b want 0", {d_mclk, d_sclk, d_lrck, d_rise, d_fall, d_fs, d_slot, d_busy});
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_run();
        int entry, first_rise, last_fs;
        entry = -1; first_rise = -1; last_fs = -1;
        repeat ($urandom_range(0, 3)) tick();
        en_s = 1'b1;
        for (int i = 0; i < 3 * S_P * S_NS + 8; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL run cyc %0d: got %b want %b", i, obs, model_vec());
            end
            checks++;
            if (s_rise && s_fall) begin
                errors++;
                $display("FAIL run_strobes cyc %0d: rise=%b fall=%b, want not both", i, s_rise, s_fall);
            end
            if (s_busy && entry < 0) entry = i;
            if (s_rise && first_rise < 0) first_rise = i;
            if (s_fs) begin
                checks++;
                if (!s_fall || s_slot !== 3'd0) begin
                    errors++;
                    $display("FAIL run_fs_align cyc %0d: fall=%b slot=%0d want fall=1 slot=0", i, s_fall, s_slot);
                end
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != S_P * S_NS) begin
                        errors++;
                        $display("FAIL run_fs_period: got %0d want %0d", i - last_fs, S_P * S_NS);
                    end
                end
                last_fs = i;
            end
        end
        checks++;
        if (first_rise - entry != S_P / 2) begin
            errors++;
            $display("FAIL run_first_rise: got %0d want %0d", first_rise - entry, S_P / 2);
        end
    endtask

    task automatic test_en_glitch();
        bit got;
        int d;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL glitch_wait cyc %0d: got %b want %b", i, obs, model_vec());
            end
            if (m_run && m_slot() == 2 && m_ph() == 1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL glitch_wait timeout: got none want slot 2");
        end
        d = $urandom_range(1, S_P - 1);
        en_s = 1'b0;
        repeat (d) tick();
        en_s = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== model_vec() || !s_busy) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_drain();
        bit got;
        int n, fs_seen;
        got = 1'b0; n = 0; fs_seen = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            if (m_run && m_slot() == 5 && m_ph() == 1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drain_wait timeout: got none want slot 5");
        end
        en_s = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            n = i;
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL drain cyc %0d: got %b want %b", i, obs, model_vec());
            end
            if (s_fs) fs_seen++;
            if (!m_run) break;
        end
        checks++;
        if (n != 2 * S_P + S_P - 1) begin
            errors++;
            $display("FAIL drain_len: got %0d want %0d", n, 2 * S_P + S_P - 1);
        end
        checks++;
        if (fs_seen != 0 || s_busy || s_sclk || s_lrck || s_slot !== 3'd0) begin
            errors++;
            $display("FAIL drain_end: fs=%0d busy=%b sclk=%b lrck=%b slot=%0d want all 0",
                     fs_seen, s_busy, s_sclk, s_lrck, s_slot);
        end
    endtask

    task automatic test_drain_resume();
        bit got;
        int fs_seen;
        fs_seen = 0;
        en_s = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL resume_wait cyc %0d: got %b want %b", i, obs, model_vec());
            end
            if (m_run && m_slot() == 5 && m_ph() == 1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resume_wait timeout: got none want slot 5");
        end
        en_s = 1'b0;
        repeat (S_P) begin
            tick();
            checks++;
            if (obs !== model_vec() || !s_busy) begin
                errors++;
                $display("FAIL resume_drain: got %b want %b", obs, model_vec());
            end
        end
        en_s = 1'b1;
        for (int i = 0; i < 2 * S_P + 4; i++) begin
            tick();
            checks++;
            if (obs !== model_vec() || !s_busy) begin
                errors++;
                $display("FAIL resume cyc %0d: got %b want %b", i, obs, model_vec());
            end
            if (s_fs) fs_seen++;
        end
        checks++;
        if (fs_seen != 1) begin
            errors++;
            $display("FAIL resume_fs: got %0d want 1", fs_seen);
        end
    endtask

    task automatic test_final_stop();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL final_wait cyc %0d: got %b want %b", i, obs, model_vec());
            end
            if (m_run && ((m_n + 1) % S_P) == 0 && (((m_n + 1) / S_P) % S_NS) == 0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL final_wait timeout: got none want last slot");
        end
        en_s = 1'b0;
        tick();
        checks++;
        if (obs !== model_vec() || s_busy || !s_fall || s_fs) begin
            errors++;
            $display("FAIL final_stop: got %b want %b", obs, model_vec());
        end
    endtask

    task automatic test_async_reset();
        bit got;
        en_s = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            if (m_run && m_slot() == 2 && m_ph() == 1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL areset_wait timeout: got none want slot 2");
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL areset_drop: got %b want %b", obs, 10'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL areset_restart cyc %0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) en_s = ~en_s;
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: en=%b got %b want %b", i, en_s, obs, model_vec());
            end
        end
        en_s = 1'b0;
    endtask

    task automatic test_defaults();
        bit got;
        int mh, sh, lh, fsc, lm, ls, ll;
        logic pm, ps, pl;
        got = 1'b0;
        en_d = 1'b1;
        for (int i = 0; i < 2 * D_P * D_NS + 200 && !got; i++) begin
            tick();
            if (d_fs) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL def_wait timeout: got no frame_start want one");
        end
        mh = 0; sh = 0; lh = 0; fsc = 0; lm = -1; ls = -1; ll = -1;
        pm = d_mclk; ps = d_sclk; pl = d_lrck;
        for (int i = 1; i <= 2 * D_P * D_NS; i++) begin
            tick();
            if (d_mclk) mh++;
            if (d_sclk) sh++;
            if (d_lrck) lh++;
            if (d_mclk && !pm) begin
                if (lm >= 0) begin
                    checks++;
                    if (i - lm != D_MD) begin
                        errors++;
                        $display("FAIL def_mclk_period: got %0d want %0d", i - lm, D_MD);
                    end
                end
                lm = i;
            end
            if (d_sclk && !ps) begin
                if (ls >= 0) begin
                    checks++;
                    if (i - ls != D_P) begin
                        errors++;
                        $display("FAIL def_sclk_period: got %0d want %0d", i - ls, D_P);
                    end
                end
                ls = i;
            end
            if (d_lrck && !pl) begin
                if (ll >= 0) begin
                    checks++;
                    if (i - ll != D_P * D_NS) begin
                        errors++;
                        $display("FAIL def_lrck_period: got %0d want %0d", i - ll, D_P * D_NS);
                    end
                end
                ll = i;
            end
            if (d_fs) begin
                fsc++;
                checks++;
                if (!d_fall || d_slot !== 6'd0) begin
                    errors++;
                    $display("FAIL def_fs_align: fall=%b slot=%0d want 1/0", d_fall, d_slot);
                end
            end
            pm = d_mclk; ps = d_sclk; pl = d_lrck;
        end
        checks++;
        if (mh != D_P * D_NS || sh != D_P * D_NS || lh != D_P * D_NS) begin
            errors++;
            $display("FAIL def_duty: mclk=%0d sclk=%0d lrck=%0d want %0d each", mh, sh, lh, D_P * D_NS);
        end
        checks++;
        if (fsc != 2) begin
            errors++;
            $display("FAIL def_fs_count: got %0d want 2", fsc);
        end
        en_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_run();
        test_en_glitch();
        test_drain();
        test_drain_resume();
        test_final_stop();
        test_async_reset();
        test_random();
        test_defaults();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
